// File: rtl/isa_io_target_if.sv
// Bus bundle for the ISA I/O target: ISA pins, the local register port, the
// interrupt controls and a debug view of the responder state.
//
// Handshake: an ISA cycle is requested by a strobe (IOR or IOW) going low
// while A is stable. The target is ready when IOCHRDY_n is 0. On reads, D_out
// is valid whenever D_oe is 1. A cycle ends when its strobe returns high.
// Local port: loc_write and loc_read are single-cycle strobes. loc_readdata is
// valid on the cycle after loc_read and holds its value until the next read.
interface isa_io_target_if;
    logic [15:0] A;
    logic [15:0] D_in;
    logic [15:0] D_out;
    logic        D_oe;
    logic        IOR;
    logic        IOW;
    logic        AEN;
    logic        IOCHRDY_n;
    logic        IRQ;
    logic [2:0]  loc_address;
    logic        loc_write;
    logic [15:0] loc_writedata;
    logic        loc_read;
    logic [15:0] loc_readdata;
    logic        irq_set;
    logic        isa_wr_pulse;
    logic [2:0]  isa_wr_index;
    logic [2:0]  dbg_state;

    modport slave (
        input  A, D_in, IOR, IOW, AEN,
        input  loc_address, loc_write, loc_writedata, loc_read, irq_set,
        output D_out, D_oe, IOCHRDY_n, IRQ, loc_readdata,
        output isa_wr_pulse, isa_wr_index, dbg_state
    );

    modport master (
        output A, D_in, IOR, IOW, AEN,
        output loc_address, loc_write, loc_writedata, loc_read, irq_set,
        input  D_out, D_oe, IOCHRDY_n, IRQ, loc_readdata,
        input  isa_wr_pulse, isa_wr_index, dbg_state
    );
endinterface

// File: rtl/isa_io_target.sv
// ISA I/O slave responder. It decodes an 8-register window at BASE_ADDR,
// inserts IOCHRDY wait states on reads, and exposes the same registers to the
// SoC through a local port. Register 7 is a read-only status register:
// {14'b0, busy, IRQ}.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h0220,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    isa_io_target_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_HOLD = 3'd2,
        WR_WAIT = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ior_s1, r_ior_s2, r_ior_s3;
    logic        r_iow_s1, r_iow_s2, r_iow_s3;
    logic        r_aen_s1, r_aen_s2, r_aen_s3;
    logic [15:0] r_regs [0:6];
    logic [2:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_dout, w_dout_nxt;
    logic        r_doe, w_doe_nxt;
    logic        r_rdy_n, w_rdy_n_nxt;
    logic        r_irq;
    logic [15:0] r_rdata;
    logic        r_wr_pulse;
    logic [2:0]  r_wr_index;
    logic        w_commit, w_irq_clr;
    logic        w_ior_fall, w_iow_fall, w_iow_rise, w_aen_rise, w_hit;
    logic [15:0] w_isa_rdval, w_loc_rdval;

    assign w_ior_fall = r_ior_s3 & ~r_ior_s2;
    assign w_iow_fall = r_iow_s3 & ~r_iow_s2;
    assign w_iow_rise = ~r_iow_s3 & r_iow_s2;
    assign w_aen_rise = ~r_aen_s3 & r_aen_s2;
    assign w_hit      = (bus.A[15:3] == BASE_ADDR[15:3]) && !r_aen_s2;

    // ISA read value. The status register reports busy=1 here because the
    // read that latches it is already in progress.
    always_comb begin
        w_isa_rdval = 16'h0000;
        if (bus.A[2:0] == 3'd7) w_isa_rdval = {14'b0, 1'b1, r_irq};
        else                    w_isa_rdval = r_regs[bus.A[2:0]];
    end

    // Local read value: status reflects the live responder state.
    always_comb begin
        w_loc_rdval = 16'h0000;
        if (bus.loc_address == 3'd7) w_loc_rdval = {14'b0, r_state != IDLE, r_irq};
        else                         w_loc_rdval = r_regs[bus.loc_address];
    end

    // Next-state and registered-output decisions for the ISA responder.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_doe_nxt   = r_doe;
        w_rdy_n_nxt = r_rdy_n;
        w_commit    = 1'b0;
        w_irq_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit && w_ior_fall && w_iow_fall) begin
                    w_state_nxt = RELEASE;
                    w_idx_nxt   = bus.A[2:0];
                end else if (w_hit && w_ior_fall) begin
                    w_state_nxt = RD_WAIT;
                    w_idx_nxt   = bus.A[2:0];
                    w_dout_nxt  = w_isa_rdval;
                    w_doe_nxt   = 1'b1;
                    w_rdy_n_nxt = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end else if (w_hit && w_iow_fall) begin
                    w_state_nxt = WR_WAIT;
                    w_idx_nxt   = bus.A[2:0];
                end
            end
            RD_WAIT: begin
                // Counter was loaded with WAIT_CYCLES, so IOCHRDY_n stays high
                // for exactly WAIT_CYCLES clocks.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RD_HOLD;
                    w_rdy_n_nxt = 1'b0;
                end
            end
            RD_HOLD: begin
                if (r_ior_s2) begin
                    w_state_nxt = IDLE;
                    w_doe_nxt   = 1'b0;
                    w_irq_clr   = (r_idx == 3'd7);
                end
            end
            WR_WAIT: begin
                if (w_iow_rise) begin
                    w_state_nxt = IDLE;
                    w_commit    = (r_idx != 3'd7);
                end
            end
            RELEASE: begin
                if (r_ior_s2 && r_iow_s2) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A DMA cycle starting under an active cycle aborts it silently.
        if (r_state != IDLE && w_aen_rise) begin
            w_state_nxt = RELEASE;
            w_doe_nxt   = 1'b0;
            w_rdy_n_nxt = 1'b0;
            w_cnt_nxt   = 4'd0;
            w_commit    = 1'b0;
            w_irq_clr   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Synchronizers, datapath, register bank, IRQ and local read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            {r_ior_s1, r_ior_s2, r_ior_s3} <= 3'b111;
            {r_iow_s1, r_iow_s2, r_iow_s3} <= 3'b111;
            {r_aen_s1, r_aen_s2, r_aen_s3} <= 3'b000;
            for (int i = 0; i < 7; i++) r_regs[i] <= 16'h0000;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_dout     <= 16'h0000;
            r_doe      <= 1'b0;
            r_rdy_n    <= 1'b0;
            r_irq      <= 1'b0;
            r_rdata    <= 16'h0000;
            r_wr_pulse <= 1'b0;
            r_wr_index <= 3'd0;
        end else begin
            {r_ior_s3, r_ior_s2, r_ior_s1} <= {r_ior_s2, r_ior_s1, bus.IOR};
            {r_iow_s3, r_iow_s2, r_iow_s1} <= {r_iow_s2, r_iow_s1, bus.IOW};
            {r_aen_s3, r_aen_s2, r_aen_s1} <= {r_aen_s2, r_aen_s1, bus.AEN};
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_doe   <= w_doe_nxt;
            r_rdy_n <= w_rdy_n_nxt;
            // The ISA commit is written after the local write, so the ISA data
            // wins when both target the same register in the same cycle.
            if (bus.loc_write && bus.loc_address != 3'd7)
                r_regs[bus.loc_address] <= bus.loc_writedata;
            if (w_commit) begin
                r_regs[r_idx] <= bus.D_in;
                r_wr_index    <= r_idx;
            end
            r_wr_pulse <= w_commit;
            if (bus.irq_set)     r_irq <= 1'b1;
            else if (w_irq_clr)  r_irq <= 1'b0;
            if (bus.loc_read)    r_rdata <= w_loc_rdval;
        end
    end

    assign bus.D_out        = r_dout;
    assign bus.D_oe         = r_doe;
    assign bus.IOCHRDY_n    = r_rdy_n;
    assign bus.IRQ          = r_irq;
    assign bus.loc_readdata = r_rdata;
    assign bus.isa_wr_pulse = r_wr_pulse;
    assign bus.isa_wr_index = r_wr_index;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_isa_io_target.sv
// Testbench for isa_io_target. It drives the ISA pins and the local port, and
// keeps a register/IRQ reference model computed from the address-window and
// register rules.
module tb_isa_io_target;
    localparam int WAIT_CYCLES = 2;

    // Clock and reset.
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    isa_io_target_if bus();

    isa_io_target #(.BASE_ADDR(16'h0220), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model and scoreboard.
    logic [15:0] exp_regs [0:6];
    logic        exp_irq;
    logic [15:0] exp_q [$];

    function automatic logic is_hit(input logic [15:0] addr, input logic aen);
        return (addr >= 16'h0220) && (addr <= 16'h0227) && !aen;
    endfunction

    function automatic logic [15:0] model_isa_read(input logic [2:0] idx);
        if (idx == 3'd7) return {14'b0, 1'b1, exp_irq};
        return exp_regs[idx];
    endfunction

    // Driver tasks.
    task automatic idle_bus();
        bus.A = 16'h0; bus.D_in = 16'h0; bus.IOR = 1'b1; bus.IOW = 1'b1; bus.AEN = 1'b0;
        bus.loc_address = 3'd0; bus.loc_write = 1'b0; bus.loc_writedata = 16'h0;
        bus.loc_read = 1'b0; bus.irq_set = 1'b0;
    endtask

    task automatic pulse_irq();
        @(negedge clk); bus.irq_set = 1'b1;
        @(negedge clk); bus.irq_set = 1'b0;
        exp_irq = 1'b1;
    endtask

    task automatic loc_wr(input logic [2:0] idx, input logic [15:0] data);
        @(negedge clk);
        bus.loc_address = idx; bus.loc_writedata = data; bus.loc_write = 1'b1;
        @(negedge clk);
        bus.loc_write = 1'b0;
        if (idx != 3'd7) exp_regs[idx] = data;
    endtask

    task automatic loc_rd_check(input logic [2:0] idx, input string name);
        logic [15:0] e;
        exp_q.push_back(idx == 3'd7 ? {14'b0, 1'b0, exp_irq} : exp_regs[idx]);
        @(negedge clk);
        bus.loc_address = idx; bus.loc_read = 1'b1;
        @(negedge clk);
        bus.loc_read = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.loc_readdata !== e)
            $display("FAIL %s: loc_readdata got %h expected %h", name, bus.loc_readdata, e);
        if (bus.loc_readdata !== e) errors++;
    endtask

    task automatic isa_write(input logic [15:0] addr, input logic [15:0] data,
                             input logic aen, input string name);
        int pulses;
        int doe_seen;
        logic exp_pulse;
        pulses = 0; doe_seen = 0;
        exp_pulse = is_hit(addr, aen) && (addr[2:0] != 3'd7);
        @(negedge clk);
        bus.A = addr; bus.AEN = aen; bus.D_in = data; bus.IOW = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.D_oe) doe_seen++;
            if (bus.isa_wr_pulse) pulses++;
        end
        bus.IOW = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.D_oe) doe_seen++;
            if (bus.isa_wr_pulse) pulses++;
        end
        checks++;
        if (pulses !== (exp_pulse ? 1 : 0)) begin
            errors++;
            $display("FAIL %s: wr_pulse count got %0d expected %0d", name, pulses, exp_pulse ? 1 : 0);
        end
        checks++;
        if (doe_seen !== 0) begin
            errors++;
            $display("FAIL %s: D_oe during write got %0d cycles expected 0", name, doe_seen);
        end
        if (exp_pulse) begin
            exp_regs[addr[2:0]] = data;
            checks++;
            if (bus.isa_wr_index !== addr[2:0]) begin
                errors++;
                $display("FAIL %s: isa_wr_index got %0d expected %0d", name, bus.isa_wr_index, addr[2:0]);
            end
        end
        bus.AEN = 1'b0;
    endtask

    task automatic isa_read(input logic [15:0] addr, input logic aen,
                            input logic irq_collide, input string name);
        logic hit;
        int first_hi, hi_cnt, doe_cnt, drop_at;
        logic [15:0] got, e;
        hit = is_hit(addr, aen);
        first_hi = -1; hi_cnt = 0; doe_cnt = 0; drop_at = -1;
        if (hit) exp_q.push_back(model_isa_read(addr[2:0]));
        @(negedge clk);
        bus.A = addr; bus.AEN = aen; bus.IOR = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.IOCHRDY_n) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = n;
            end
            if (bus.D_oe) doe_cnt++;
        end
        got = bus.D_out;
        if (hit) begin
            e = exp_q.pop_front();
            checks++;
            if (first_hi !== 3) begin
                errors++;
                $display("FAIL %s: IOCHRDY_n first high at sample %0d expected 3", name, first_hi);
            end
            checks++;
            if (hi_cnt !== WAIT_CYCLES) begin
                errors++;
                $display("FAIL %s: IOCHRDY_n high cycles got %0d expected %0d", name, hi_cnt, WAIT_CYCLES);
            end
            checks++;
            if (bus.D_oe !== 1'b1) begin
                errors++;
                $display("FAIL %s: D_oe in hold got %b expected 1", name, bus.D_oe);
            end
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: D_out got %h expected %h", name, got, e);
            end
        end else begin
            checks++;
            if (hi_cnt !== 0 || doe_cnt !== 0) begin
                errors++;
                $display("FAIL %s: miss responded IOCHRDY_n=%0d D_oe=%0d cycles expected 0/0", name, hi_cnt, doe_cnt);
            end
        end
        bus.IOR = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (drop_at < 0 && !bus.D_oe) drop_at = n;
            if (irq_collide && n == 2) bus.irq_set = 1'b1;
            if (irq_collide && n == 3) bus.irq_set = 1'b0;
        end
        if (hit) begin
            checks++;
            if (drop_at !== 3) begin
                errors++;
                $display("FAIL %s: D_oe release at sample %0d expected 3", name, drop_at);
            end
            if (addr[2:0] == 3'd7) exp_irq = 1'b0;
        end
        if (irq_collide) exp_irq = 1'b1;
        checks++;
        if (bus.IRQ !== exp_irq) begin
            errors++;
            $display("FAIL %s: IRQ after read got %b expected %b", name, bus.IRQ, exp_irq);
        end
        bus.AEN = 1'b0;
    endtask

    // Scenario tasks.
    task automatic test_reset();
        checks++;
        if (bus.D_oe !== 1'b0 || bus.D_out !== 16'h0 || bus.IOCHRDY_n !== 1'b0 || bus.IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: D_oe=%b D_out=%h IOCHRDY_n=%b IRQ=%b expected 0/0000/0/0",
                     bus.D_oe, bus.D_out, bus.IOCHRDY_n, bus.IRQ);
        end
        checks++;
        if (bus.loc_readdata !== 16'h0 || bus.isa_wr_pulse !== 1'b0 || bus.isa_wr_index !== 3'd0 || bus.dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_local: readdata=%h pulse=%b index=%0d state=%0d expected 0",
                     bus.loc_readdata, bus.isa_wr_pulse, bus.isa_wr_index, bus.dbg_state);
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 8; i++) loc_rd_check(3'(i), "reset_regs");
    endtask

    task automatic test_isa_write();
        isa_write(16'h0222, 16'h1234, 1'b0, "isa_write_idx2");
        loc_rd_check(3'd2, "isa_write_readback");
        isa_write(16'h0227, 16'hFFFF, 1'b0, "isa_write_status_ignored");
        loc_rd_check(3'd7, "status_after_write7");
    endtask

    task automatic test_isa_read();
        loc_wr(3'd5, 16'hBEEF);
        isa_read(16'h0225, 1'b0, 1'b0, "isa_read_idx5");
        loc_wr(3'd7, 16'hAAAA);
        loc_rd_check(3'd7, "loc_write7_ignored");
    endtask

    task automatic test_miss();
        isa_write(16'h0230, 16'hDEAD, 1'b0, "miss_write_addr");
        isa_read(16'h0230, 1'b0, 1'b0, "miss_read_addr");
        isa_write(16'h0221, 16'hDEAD, 1'b1, "miss_write_aen");
        isa_read(16'h0221, 1'b1, 1'b0, "miss_read_aen");
        loc_rd_check(3'd0, "miss_regs0");
        loc_rd_check(3'd1, "miss_regs1");
    endtask

    task automatic test_irq();
        pulse_irq();
        checks++;
        if (bus.IRQ !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: IRQ got %b expected 1", bus.IRQ);
        end
        isa_read(16'h0227, 1'b0, 1'b0, "irq_status_read");
        pulse_irq();
        isa_read(16'h0227, 1'b0, 1'b1, "irq_set_clear_same_cycle");
        isa_read(16'h0227, 1'b0, 1'b0, "irq_second_clear");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.A = 16'h0223; bus.D_in = 16'h00AA; bus.IOW = 1'b0;
        repeat (4) @(negedge clk);
        bus.IOW = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.loc_address = 3'd3; bus.loc_writedata = 16'h5555; bus.loc_write = 1'b1;
        @(negedge clk);
        bus.loc_write = 1'b0;
        checks++;
        if (bus.isa_wr_pulse !== 1'b1) begin
            errors++;
            $display("FAIL collide_pulse: isa_wr_pulse got %b expected 1", bus.isa_wr_pulse);
        end
        exp_regs[3] = 16'h00AA;
        loc_rd_check(3'd3, "collide_isa_wins");
    endtask

    task automatic test_reset_mid_read();
        int waited;
        waited = 0;
        pulse_irq();
        @(negedge clk);
        bus.A = 16'h0223; bus.IOR = 1'b0;
        while (!bus.IOCHRDY_n && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.IOCHRDY_n) begin
            errors++;
            $display("FAIL reset_mid_wait: IOCHRDY_n got 0 expected 1 within 8 cycles");
        end
        reset = 1'b0;
        @(negedge clk);
        bus.IOR = 1'b1;
        checks++;
        if (bus.D_oe !== 1'b0 || bus.IOCHRDY_n !== 1'b0 || bus.IRQ !== 1'b0 || bus.dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_read: D_oe=%b IOCHRDY_n=%b IRQ=%b state=%0d expected 0/0/0/0",
                     bus.D_oe, bus.IOCHRDY_n, bus.IRQ, bus.dbg_state);
        end
        for (int i = 0; i < 7; i++) exp_regs[i] = 16'h0;
        exp_irq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        loc_rd_check(3'd3, "reset_mid_regs3");
        loc_rd_check(3'd5, "reset_mid_regs5");
    endtask

    task automatic test_aen_abort();
        int pulses;
        logic [15:0] e;
        pulses = 0;
        loc_wr(3'd4, 16'h1111);
        @(negedge clk);
        bus.A = 16'h0224; bus.D_in = 16'h2222; bus.IOW = 1'b0;
        repeat (4) @(negedge clk);
        bus.AEN = 1'b1;
        repeat (4) @(negedge clk);
        e = {14'b0, 1'b1, exp_irq};
        bus.loc_address = 3'd7; bus.loc_read = 1'b1;
        @(negedge clk);
        bus.loc_read = 1'b0;
        checks++;
        if (bus.loc_readdata !== e) begin
            errors++;
            $display("FAIL abort_busy: status got %h expected %h", bus.loc_readdata, e);
        end
        bus.IOW = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.isa_wr_pulse) pulses++;
        end
        bus.AEN = 1'b0;
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_pulse: pulses got %0d expected 0", pulses);
        end
        repeat (3) @(negedge clk);
        loc_rd_check(3'd4, "abort_no_write");
        loc_rd_check(3'd7, "abort_back_idle");
    endtask

    task automatic test_random();
        int op;
        logic [2:0] idx;
        logic [15:0] addr;
        logic aen;
        for (int k = 0; k < 24; k++) begin
            op   = $urandom_range(0, 4);
            idx  = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 3) == 0) ? (16'h0228 + 16'(idx)) : (16'h0220 + 16'(idx));
            aen  = ($urandom_range(0, 7) == 0);
            case (op)
                0: isa_write(addr, 16'($urandom), aen, "rand_isa_write");
                1: isa_read(addr, aen, 1'b0, "rand_isa_read");
                2: loc_wr(idx, 16'($urandom));
                3: loc_rd_check(idx, "rand_loc_read");
                default: pulse_irq();
            endcase
        end
        for (int i = 0; i < 8; i++) loc_rd_check(3'(i), "rand_final_regs");
    endtask

    // Watchdog: bounds the whole run.
    initial begin
        #1000000;
        $display("FAIL watchdog: run time exceeded limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        for (int i = 0; i < 7; i++) exp_regs[i] = 16'h0;
        exp_irq = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_isa_write();
        test_isa_read();
        test_miss();
        test_irq();
        test_back_to_back();
        test_reset_mid_read();
        test_aen_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
